reg_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 32-bit write path into a bank of enable-gated 32-bit registers among NUM_REQ requesters.
- Registers of the bank capture data on a clock edge when their enable is high and otherwise hold their value.
- This block drives each bank register's enable and the common data bus, and grants at most one write per cycle.
- It sits between the decode/control units (the requesters) and the shared register bank.

---
 rtl/reg_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_reg_wr_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wr_arbiter.sv
`timescale 1ns / 1ps
// reg_wr_arbiter
//
// Round-robin arbiter that shares one write path into a bank of enable-gated
// registers among NUM_REQ requesters. Each cycle at most one requester wins.
// Its target register's enable and its write data are then driven, registered,
// during the following cycle.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       per-requester write request (level)
//   req_addr  flattened register index, requester i at [i*ADDR_W +: ADDR_W]
//   req_data  flattened write data, requester i at [i*DATA_W +: DATA_W]
//   hold      freeze arbitration; no new grants while high
//   gnt       one-hot grant pulse (registered)
//   reg_en    one-hot bank register enable (registered)
//   reg_d     data to all bank registers (registered, holds when idle)
//   busy      high whenever gnt is nonzero
module reg_wr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic                        hold,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [(1<<ADDR_W)-1:0]      reg_en,
    output logic [DATA_W-1:0]           reg_d,
    output logic                        busy
);

    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Registered state
    logic [NUM_REQ-1:0] gnt_q,    gnt_d;
    logic [NREG-1:0]    reg_en_q, reg_en_d;
    logic [DATA_W-1:0]  reg_d_q,  reg_d_d;
    logic               busy_q,   busy_d;
    logic [PTR_W-1:0]   ptr_q,    ptr_d;

    // Per-requester views of the flattened address/data buses
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
            data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // The requester holding the grant this cycle is masked, which forces a
    // one-cycle gap between back-to-back writes from the same source.
    logic [NUM_REQ-1:0] elig;
    assign elig = req & ~gnt_q;

    // Priority search starting at ptr and wrapping modulo NUM_REQ.
    logic               found;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   idx;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = PTR_W'((32'(ptr_q) + off) % NUM_REQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state: a grant only when not frozen and someone is eligible.
    // reg_d and ptr hold their value on idle cycles.
    always_comb begin
        gnt_d    = '0;
        reg_en_d = '0;
        reg_d_d  = reg_d_q;
        busy_d   = 1'b0;
        ptr_d    = ptr_q;
        if (!hold && found) begin
            gnt_d    = NUM_REQ'(1) << win;
            reg_en_d = NREG'(1) << addr_arr[win];
            reg_d_d  = data_arr[win];
            busy_d   = 1'b1;
            if (win == PTR_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win + PTR_W'(1);
            end
        end
    end

    // Async clear guarantees no partial write escapes once rst_n drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q    <= '0;
            reg_en_q <= '0;
            reg_d_q  <= '0;
            busy_q   <= 1'b0;
            ptr_q    <= '0;
        end else begin
            gnt_q    <= gnt_d;
            reg_en_q <= reg_en_d;
            reg_d_q  <= reg_d_d;
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
        end
    end

    assign gnt    = gnt_q;
    assign reg_en = reg_en_q;
    assign reg_d  = reg_d_q;
    assign busy   = busy_q;

    // Structural invariants of the outputs
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_q));
    a_en_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(reg_en_q));
    a_en_matches_gnt : assert property (@(posedge clk) disable iff (!rst_n)
        ((gnt_q == '0) == (reg_en_q == '0)));
    a_busy_matches_gnt : assert property (@(posedge clk) disable iff (!rst_n)
        (busy_q == (gnt_q != '0)));

endmodule

// File: tb/tb_reg_wr_arbiter.sv
`timescale 1ns / 1ps
// Self-checking bench for reg_wr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_reg_wr_arbiter;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int NR = 1 << AW;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            hold;
    logic [N-1:0]    gnt;
    logic [NR-1:0]   reg_en;
    logic [DW-1:0]   reg_d;
    logic            busy;

    reg_wr_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .hold     (hold),
        .gnt      (gnt),
        .reg_en   (reg_en),
        .reg_d    (reg_d),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: who holds the grant, where priority starts, bus contents
    int            m_winner;  // -1 when idle
    int            m_ptr;
    logic [DW-1:0] m_d;
    logic [NR-1:0] m_en;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_winner = -1;
        m_ptr    = 0;
        m_d      = '0;
        m_en     = '0;
    endtask

    // One edge of the arbitration rules, evaluated on the inputs at that edge
    task automatic model_edge();
        int w;
        w = -1;
        if (!hold) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (w < 0 && req[i] && i != m_winner) w = i;
            end
        end
        m_winner = w;
        if (w < 0) begin
            m_en = '0;
        end else begin
            m_en  = '0;
            m_en[req_addr[w*AW +: AW]] = 1'b1;
            m_d   = req_data[w*DW +: DW];
            m_ptr = (w + 1) % N;
        end
    endtask

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_winner >= 0) g[m_winner] = 1'b1;
        return g;
    endfunction

    task automatic compare_all(input string tag);
        check_eq({tag, ".gnt"},    64'(gnt),    64'(m_gnt()));
        check_eq({tag, ".reg_en"}, 64'(reg_en), 64'(m_en));
        check_eq({tag, ".reg_d"},  64'(reg_d),  64'(m_d));
        check_eq({tag, ".busy"},   64'(busy),   64'(m_winner >= 0));
    endtask

    // Inputs are already set; advance one edge, update model, sample #1 later
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    logic [N-1:0] g1, g2;
    int           cnt [N];
    int           pat [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        hold     = 1'b0;
        req_addr = '0;
        req_data = '0;
        model_reset();
        #3;
        compare_all("reset");
        #9;  // t=12, between edges
        rst_n = 1'b1;

        // Round-robin with all requesting: 0 first, then rotating
        for (int i = 0; i < N; i++) set_slot(i, AW'(i), DW'(32'h100 + i));
        for (int i = 0; i < N; i++) cnt[i] = 0;
        req = 4'b1111;
        step("rr0");
        check_eq("rr_first_is_0", 64'(gnt), 64'h1);
        cnt[0]++;
        for (int c = 1; c < 2 * N; c++) begin
            g1 = gnt;
            step("rr");
            check_eq("rr_no_repeat", 64'(gnt == g1), 64'h0);
            for (int i = 0; i < N; i++) if (gnt[i]) cnt[i]++;
        end
        for (int i = 0; i < N; i++) check_eq("rr_fair", 64'(cnt[i] >= 1), 64'h1);

        req = '0;
        step("idle");

        // Single request
        set_slot(2, 3'd5, 32'hDEADBEEF);
        req = 4'b0100;
        step("single");
        check_eq("single_gnt", 64'(gnt), 64'h4);
        check_eq("single_en",  64'(reg_en), 64'h20);
        check_eq("single_d",   64'(reg_d), 64'hDEADBEEF);
        check_eq("single_busy", 64'(busy), 64'h1);
        req = '0;
        step("single_after");
        check_eq("single_after_gnt", 64'(gnt), 64'h0);
        check_eq("single_after_en",  64'(reg_en), 64'h0);
        check_eq("single_after_busy", 64'(busy), 64'h0);

        // Same-requester gap
        pat = '{1, 0, 1, 0, 1, 0};
        req = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            step("gap");
            check_eq("gap_pattern", 64'(gnt[0]), 64'(pat[c]));
        end
        req = '0;
        step("gap_end");

        // Hold blocks grants; both requesters served once released
        req  = 4'b0011;
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step("hold");
            check_eq("hold_no_gnt", 64'(gnt), 64'h0);
        end
        hold = 1'b0;
        step("hold_rel1");
        g1 = gnt;
        step("hold_rel2");
        g2 = gnt;
        check_eq("hold_both_served", 64'(g1 | g2), 64'h3);
        check_eq("hold_distinct", 64'(g1 & g2), 64'h0);
        req = '0;
        step("hold_end");

        // Wrap and address conflict: grant 2 leaves ptr at 3
        set_slot(2, 3'd1, 32'h55);
        req = 4'b0100;
        step("wrap_pre");
        set_slot(0, 3'd7, 32'h2);
        set_slot(3, 3'd7, 32'h1);
        req = 4'b1001;
        step("wrap1");
        check_eq("wrap1_gnt", 64'(gnt), 64'h8);
        check_eq("wrap1_en",  64'(reg_en), 64'h80);
        check_eq("wrap1_d",   64'(reg_d), 64'h1);
        step("wrap2");
        check_eq("wrap2_gnt", 64'(gnt), 64'h1);
        check_eq("wrap2_en",  64'(reg_en), 64'h80);
        check_eq("wrap2_d",   64'(reg_d), 64'h2);
        req = '0;
        step("wrap_end");

        // Reset mid-grant clears outputs immediately, ptr back to 0
        set_slot(1, 3'd3, 32'hCAFE);
        req = 4'b0010;
        step("mid_pre");
        check_eq("mid_pre_gnt", 64'(gnt), 64'h2);
        req = '0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("mid_reset");
        #2;
        rst_n = 1'b1;
        req = 4'b1111;
        step("post_reset");
        check_eq("post_reset_gnt", 64'(gnt), 64'h1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            req  = N'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) set_slot(i, AW'($urandom), $urandom);
            step("rand");
            check_eq("rand_en_onehot0", 64'($onehot0(reg_en)), 64'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
